// File: rtl/iterative_divider_pkg.sv
// -----------------------------------------------------------------------------
// iterative_divider_pkg
// Shared encodings for the RV32M multi-cycle divide unit.
//   DIV_OP_*   : 2-bit function select, equal to funct3[1:0]
//   DIV_IDLE/DIV_RUN/DIV_DONE : controller state encodings
//   op_is_rem / op_is_signed : small decode helpers for the op field
// -----------------------------------------------------------------------------
package iterative_divider_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // REM / REMU return the remainder, DIV / DIVU the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    // DIV / REM treat operands as two's-complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// -----------------------------------------------------------------------------
// iterative_divider_div_step
// One combinational restoring-division step.
//   rem_in       : current partial remainder (always < divisor, fits WIDTH bits)
//   dividend_bit : next dividend bit shifted in at the LSB
//   divisor      : divisor magnitude
//   rem_out      : partial remainder after the step
//   q_bit        : resolved quotient bit
// -----------------------------------------------------------------------------
module iterative_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction is one bit wider so the borrow lands in trial[WIDTH].
    assign shifted = {rem_in, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};

    // Both the kept difference and the restored value are below the divisor,
    // so dropping the top bit loses nothing.
    always_comb begin
        if (!trial[WIDTH]) begin
            rem_out = trial[WIDTH-1:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted[WIDTH-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU), restoring shift-subtract,
// one quotient bit per clock.
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : request pulse, accepted when not busy (IDLE or DONE)
//   operation  : funct3[1:0] - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand_a  : dividend, sampled on the accepting edge
//   operand_b  : divisor, sampled on the accepting edge
//   busy       : high while iterating (RUN)
//   done       : one-cycle pulse, result valid in that cycle
//   result     : quotient or remainder, held until the next accepted start
// Optional build macro ITERATIVE_DIVIDER_EARLY_OUT_EN: when |a| < |b| the
// answer is known at accept and RUN is skipped. Results are identical either
// way, only latency changes.
// -----------------------------------------------------------------------------
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dividend_reg;   // dividend bits shift out the top, quotient bits fill the bottom
    logic [WIDTH-1:0] divisor_reg;
    logic             op_rem_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;

    // Accept-time decode of the incoming request.
    logic             in_rem;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             early_out;

    always_comb begin
        in_rem    = op_is_rem(operation);
        in_signed = op_is_signed(operation);
        a_neg     = in_signed & operand_a[WIDTH-1];
        b_neg     = in_signed & operand_b[WIDTH-1];
        a_mag     = a_neg ? (WIDTH'(0) - operand_a) : operand_a;
        b_mag     = b_neg ? (WIDTH'(0) - operand_b) : operand_b;
        div_zero  = (operand_b == '0);
        overflow  = in_signed && (operand_a == MIN_NEG) && (&operand_b);
`ifdef ITERATIVE_DIVIDER_EARLY_OUT_EN
        early_out = (a_mag < b_mag);
`else
        early_out = 1'b0;
`endif
    end

    // RUN datapath: one restoring step per edge.
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    iterative_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in       (rem_reg),
        .dividend_bit (dividend_reg[WIDTH-1]),
        .divisor      (divisor_reg),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Final values as they would stand after the current step; only
    // registered on the last RUN edge.
    logic [WIDTH-1:0] q_full;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        q_full  = {dividend_reg[WIDTH-2:0], step_q};
        q_final = q_neg_reg ? (WIDTH'(0) - q_full)   : q_full;
        r_final = r_neg_reg ? (WIDTH'(0) - step_rem) : step_rem;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= DIV_IDLE;
            counter_reg  <= '0;
            rem_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            op_rem_reg   <= 1'b0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                DIV_IDLE, DIV_DONE: begin
                    if (start) begin
                        op_rem_reg   <= in_rem;
                        q_neg_reg    <= a_neg ^ b_neg;
                        r_neg_reg    <= a_neg;
                        dividend_reg <= a_mag;
                        divisor_reg  <= b_mag;
                        rem_reg      <= '0;
                        if (div_zero) begin
                            result_reg <= in_rem ? operand_a : '1;
                            state_reg  <= DIV_DONE;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                        end else if (overflow) begin
                            result_reg <= in_rem ? '0 : operand_a;
                            state_reg  <= DIV_DONE;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                        end else if (early_out) begin
                            // Quotient is zero and the dividend is already the remainder.
                            result_reg <= in_rem ? operand_a : '0;
                            state_reg  <= DIV_DONE;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                        end else begin
                            counter_reg <= CNT_W'(WIDTH);
                            state_reg   <= DIV_RUN;
                            busy_reg    <= 1'b1;
                            done_reg    <= 1'b0;
                        end
                    end else begin
                        state_reg <= DIV_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                end

                DIV_RUN: begin
                    rem_reg      <= step_rem;
                    dividend_reg <= q_full;
                    counter_reg  <= counter_reg - CNT_W'(1);
                    if (counter_reg == CNT_W'(1)) begin
                        result_reg <= op_rem_reg ? r_final : q_final;
                        state_reg  <= DIV_DONE;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= DIV_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
// Directed vectors with hand-computed results for the iterative divider.
// Latency is counted in rising edges from the accepting edge N up to and
// including the edge that raises done (special cases 1, full run WIDTH+1).
// -----------------------------------------------------------------------------
module tb_iterative_divider;

    localparam int W = 32;
    localparam int FULL_LAT = W + 1;
    localparam int FAST_LAT = 1;
`ifdef ITERATIVE_DIVIDER_EARLY_OUT_EN
    localparam int EARLY_LAT = FAST_LAT;
`else
    localparam int EARLY_LAT = FULL_LAT;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   operation = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_vectors = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    iterative_divider #(
        .WIDTH (W)
    ) dut (
        .clock     (clk),
        .reset_n   (reset_n),
        .start     (start),
        .operation (operation),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // Present a request and return at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        operation = op;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Bounded wait for done; lat0 is the latency already elapsed.
    task automatic wait_done(input int lat0, output int lat, output bit busy_seen);
        lat = lat0;
        busy_seen = 1'b0;
        while (!done && lat < 200) begin
            busy_seen |= busy;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
        int lat;
        bit busy_seen;
        issue(op, a, b);
        wait_done(1, lat, busy_seen);
        check({tag, " result"}, result, exp_res);
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " busy"}, W'(busy_seen), W'(exp_lat > 1));
        @(negedge clk);
        check({tag, " done drop"}, W'(done), W'(0));
        check({tag, " hold"}, result, exp_res);
    endtask

    initial begin
        int lat;
        bit busy_seen;
        bit done_seen;

        repeat (3) @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", result, W'(0));
        reset_n = 1'b1;

        run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, FULL_LAT);
        run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, FULL_LAT);
        run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT);
        run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT);
        run_op("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
        run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT);
        run_op("DIVU 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, FAST_LAT);
        run_op("REM 5/0", 2'b10, 32'd5, 32'd0, 32'd5, FAST_LAT);
        run_op("DIV min/-1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT);
        run_op("REM min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FAST_LAT);
        run_op("DIVU 3/10", 2'b01, 32'd3, 32'd10, 32'd0, EARLY_LAT);
        run_op("REMU 3/10", 2'b11, 32'd3, 32'd10, 32'd3, EARLY_LAT);

        // start pulsed mid-run with different operands must be ignored.
        issue(2'b01, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        operation = 2'b11;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done(7, lat, busy_seen);
        check("ignore start result", result, 32'd14);
        check("ignore start latency", W'(lat), W'(FULL_LAT));
        @(negedge clk);

        // Back-to-back: new request accepted in the DONE cycle.
        issue(2'b01, 32'd100, 32'd7);
        wait_done(1, lat, busy_seen);
        check("b2b first result", result, 32'd14);
        operation = 2'b11;
        operand_a = 32'd100;
        operand_b = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        check("b2b busy", W'(busy), W'(1));
        check("b2b done low", W'(done), W'(0));
        wait_done(1, lat, busy_seen);
        check("b2b second result", result, 32'd2);
        check("b2b second latency", W'(lat), W'(FULL_LAT));
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        issue(2'b01, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun reset busy", W'(busy), W'(0));
        check("midrun reset done", W'(done), W'(0));
        check("midrun reset result", result, W'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            done_seen |= done;
        end
        check("no done after reset", W'(done_seen), W'(0));
        run_op("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, FULL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
